// File: rtl/imem_loader.sv
// imem_loader: byte-stream writer for the instruction memory.
// Collects bytes over a valid/ready link and packs them little-endian into
// 32-bit words. Each word is written to the next IMEM address, starting at
// address 0. The CPU is held until the whole program has been written.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; an illegal load_len produces a one-cycle err pulse
// RECV  | byte_ready high; packing accepted bytes into wr_data
// WRITE | single-cycle wr_en for the assembled word
// DONE  | single-cycle done pulse; cpu_hold drops as this state exits
module imem_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold,
  output logic [7:0]        csum
);

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_idx;

  logic len_ok;
  logic last_word;
  logic load_go;
  logic load_bad;
  logic accept;
  logic word_full;

  assign len_ok    = (load_len != '0) && (load_len <= MAX_LEN);
  assign last_word = ({1'b0, word_idx} == (len - ONE));
  assign word_full = accept && (byte_idx == 2'd3);

  // Next-state and per-state strobes. Strobes are gated by reset so that no
  // write or handshake leaks out during the reset cycle itself.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    load_go    = 1'b0;
    load_bad   = 1'b0;
    accept     = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              load_go   = 1'b1;
              state_nxt = RECV;
            end else begin
              load_bad  = 1'b1;
            end
          end
        end
        RECV: begin
          byte_ready = 1'b1;
          busy       = 1'b1;
          accept     = byte_valid;
          if (byte_valid && (byte_idx == 2'd3)) begin
            state_nxt = WRITE;
          end
        end
        WRITE: begin
          wr_en     = 1'b1;
          busy      = 1'b1;
          state_nxt = last_word ? DONE : RECV;
        end
        DONE: begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Load length and word/byte position counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      len      <= '0;
      word_idx <= '0;
      byte_idx <= '0;
    end else begin
      if (load_go) begin
        len      <= load_len;
        word_idx <= '0;
        byte_idx <= '0;
      end else if (accept) begin
        byte_idx <= byte_idx + 2'd1;
      end else if (wr_en) begin
        byte_idx <= '0;
        if (!last_word) begin
          word_idx <= word_idx + 1'b1;
        end
      end
    end
  end

  // Word assembly: each accepted byte lands in its lane of wr_data, so the
  // register already holds the finished word when WRITE is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_data <= '0;
    end else if (accept) begin
      case (byte_idx)
        2'd0:    wr_data[7:0]   <= byte_in;
        2'd1:    wr_data[15:8]  <= byte_in;
        2'd2:    wr_data[23:16] <= byte_in;
        default: wr_data[31:24] <= byte_in;
      endcase
    end
  end

  // Write address is latched as the word completes and then held, so it
  // stays stable through WRITE and afterwards until the next word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr <= '0;
    end else if (word_full) begin
      wr_addr <= word_idx;
    end
  end

  // Running XOR of accepted bytes; restarted by each accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= '0;
    end else if (load_go) begin
      csum <= '0;
    end else if (accept) begin
      csum <= csum ^ byte_in;
    end
  end

  // err pulses for one cycle after a start that carried an illegal length.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= load_bad;
    end
  end

  // CPU hold: asserted out of reset and on every accepted start, released
  // as DONE exits. A rejected start leaves it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_hold <= 1'b1;
    end else if (load_go) begin
      cpu_hold <= 1'b1;
    end else if (state == DONE) begin
      cpu_hold <= 1'b0;
    end
  end

endmodule
